// File: rtl/phv_action_executor.sv
// PHV action executor: decodes the stage result opcode, applies it, and buffers
// surviving PHVs in an elastic FIFO. Define ACTION_EXEC_STATS_EN to build counters.
module phv_action_executor #(
   parameter int PHV_WIDTH      = 512,
   parameter int METADATA_WIDTH = 64,
   parameter int PORT_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int FIFO_ADDR_BITS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PORT_WIDTH-1:0]     cfg_default_port,
   input  logic                      in_valid,
   input  logic [PHV_WIDTH-1:0]      in_phv,
   input  logic [METADATA_WIDTH-1:0] in_metadata,
   input  logic [7:0]                in_action,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PHV_WIDTH-1:0]      out_phv,
   output logic [PORT_WIDTH-1:0]     out_egress_port,
   output logic                      out_mirror,
   output logic [FIFO_ADDR_BITS:0]   fifo_level,
   output logic [31:0]               drop_count,
   output logic [31:0]               overflow_count
);

   localparam int NW = PHV_WIDTH / 32;
   localparam logic [FIFO_ADDR_BITS:0] LVL_FULL = (FIFO_ADDR_BITS+1)'(FIFO_DEPTH);

   logic                  r_a_valid;
   logic [PHV_WIDTH-1:0]  r_a_phv;
   logic [31:0]           r_a_data;
   logic [3:0]            r_a_widx;
   logic [PORT_WIDTH-1:0] r_a_port;

   // Only the metadata fields the decoder needs are kept in stage A
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_valid <= 1'b0;
         r_a_phv   <= '0;
         r_a_data  <= '0;
         r_a_widx  <= '0;
         r_a_port  <= '0;
      end else begin
         r_a_valid <= in_valid;
         if (in_valid) begin
            r_a_phv  <= in_phv;
            r_a_data <= in_metadata[63:32];
            r_a_widx <= in_metadata[19:16];
            r_a_port <= in_metadata[8 +: PORT_WIDTH];
         end
      end
   end

   logic                  w_drop;
   logic                  w_mir;
   logic [PORT_WIDTH-1:0] w_port;
   logic [PHV_WIDTH-1:0]  w_phv;

   always_comb begin
      w_drop = 1'b0;
      w_mir  = 1'b0;
      w_port = cfg_default_port;
      w_phv  = r_a_phv;
      unique case (1'b1)
         (in_action == 8'h00): w_drop = 1'b1;
         (in_action == 8'h01),
         (in_action == 8'h03): w_port = r_a_port;
         (in_action == 8'h02): begin
            for (int i = 0; i < NW; i++) begin
               if (i == int'(r_a_widx)) w_phv[32*i +: 32] = r_a_data;
            end
         end
         (in_action == 8'h04): w_mir = 1'b1;
         default: ;
      endcase
   end

   logic [PHV_WIDTH-1:0]      r_mem_phv  [FIFO_DEPTH];
   logic [PORT_WIDTH-1:0]     r_mem_port [FIFO_DEPTH];
   logic                      r_mem_mir  [FIFO_DEPTH];
   logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
   logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
   logic [FIFO_ADDR_BITS:0]   r_level;
   logic [PHV_WIDTH-1:0]      r_last_phv;
   logic [PORT_WIDTH-1:0]     r_last_port;
   logic                      r_last_mir;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push_req;
   logic w_push;
   logic w_ovf;
   logic w_drop_ev;

   assign w_empty    = (r_level == '0);
   assign w_full     = (r_level == LVL_FULL);
   assign w_pop      = ~w_empty & out_ready;
   assign w_push_req = r_a_valid & ~w_drop;
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_ovf      = w_push_req & w_full & ~w_pop;
   assign w_drop_ev  = r_a_valid & w_drop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_phv[r_wr_ptr]  <= w_phv;
         r_mem_port[r_wr_ptr] <= w_port;
         r_mem_mir[r_wr_ptr]  <= w_mir;
      end
   end

   // The popped head is remembered so outputs hold once the FIFO runs dry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_last_phv  <= '0;
         r_last_port <= '0;
         r_last_mir  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_last_phv  <= r_mem_phv[r_rd_ptr];
            r_last_port <= r_mem_port[r_rd_ptr];
            r_last_mir  <= r_mem_mir[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign out_valid       = ~w_empty;
   assign fifo_level      = r_level;
   assign out_phv         = w_empty ? r_last_phv  : r_mem_phv[r_rd_ptr];
   assign out_egress_port = w_empty ? r_last_port : r_mem_port[r_rd_ptr];
   assign out_mirror      = w_empty ? r_last_mir  : r_mem_mir[r_rd_ptr];

`ifdef ACTION_EXEC_STATS_EN
   logic [31:0] r_drop_cnt;
   logic [31:0] r_ovf_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
         r_ovf_cnt  <= '0;
      end else begin
         if (w_drop_ev) r_drop_cnt <= r_drop_cnt + 32'd1;
         if (w_ovf)     r_ovf_cnt  <= r_ovf_cnt + 32'd1;
      end
   end

   assign drop_count     = r_drop_cnt;
   assign overflow_count = r_ovf_cnt;

   logic w_unused;
   assign w_unused = ^in_metadata;
`else
   assign drop_count     = '0;
   assign overflow_count = '0;

   logic w_unused;
   assign w_unused = ^{in_metadata, w_drop_ev, w_ovf};
`endif

endmodule

// File: tb/tb_phv_action_executor.sv
// Bench for phv_action_executor: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_phv_action_executor;

   logic         clk;
   logic         rst_n;
   logic [7:0]   cfg_default_port;
   logic         in_valid;
   logic [511:0] in_phv;
   logic [63:0]  in_metadata;
   logic [7:0]   in_action;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_phv;
   logic [7:0]   out_egress_port;
   logic         out_mirror;
   logic [2:0]   fifo_level;
   logic [31:0]  drop_count;
   logic [31:0]  overflow_count;

   phv_action_executor dut (
      .clk(clk), .rst_n(rst_n), .cfg_default_port(cfg_default_port),
      .in_valid(in_valid), .in_phv(in_phv), .in_metadata(in_metadata),
      .in_action(in_action), .out_valid(out_valid), .out_ready(out_ready),
      .out_phv(out_phv), .out_egress_port(out_egress_port),
      .out_mirror(out_mirror), .fifo_level(fifo_level),
      .drop_count(drop_count), .overflow_count(overflow_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [511:0] phv;
      logic [7:0]   port;
      logic         mir;
   } ent_t;

   typedef struct {
      logic [7:0]   act;
      logic [63:0]  meta;
      logic [511:0] phv;
      logic         drop;
      logic [7:0]   port;
      logic         mir;
      logic [511:0] exp_phv;
   } vec_t;

   int checks = 0;
   int failures = 0;

   ent_t         mq[$];
   ent_t         mlast;
   logic [31:0]  mdl_drop;
   logic [31:0]  mdl_ovf;
   logic         pv_valid;
   logic [511:0] pv_phv;
   logic [63:0]  pv_meta;
   logic [7:0]   pend_act;

   localparam logic [511:0] P0 = {
      32'h1000000F, 32'h1000000E, 32'h1000000D, 32'h1000000C,
      32'h1000000B, 32'h1000000A, 32'h10000009, 32'h10000008,
      32'h10000007, 32'h10000006, 32'h10000005, 32'h10000004,
      32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000};

   task automatic chk(input string nm, input logic [511:0] a,
                      input logic [511:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   function automatic logic [31:0] xs(input logic [31:0] m);
`ifdef ACTION_EXEC_STATS_EN
      return m;
`else
      return 32'd0 & m;
`endif
   endfunction

   function automatic ent_t ref_exec(input logic [511:0] phv,
                                     input logic [63:0] meta,
                                     input logic [7:0] act);
      ent_t e;
      int w;
      e.phv  = phv;
      e.port = cfg_default_port;
      e.mir  = 1'b0;
      if (act == 8'h01 || act == 8'h03) begin
         e.port = meta[15:8];
      end else if (act == 8'h02) begin
         w = int'(meta[19:16]);
         if (w < 16) e.phv[32*w +: 32] = meta[63:32];
      end else if (act == 8'h04) begin
         e.mir = 1'b1;
      end
      return e;
   endfunction

   task automatic check_state();
      ent_t h;
      h = (mq.size() != 0) ? mq[0] : mlast;
      chk("out_valid", 512'(out_valid), 512'(mq.size() != 0));
      chk("fifo_level", 512'(fifo_level), 512'(mq.size()));
      chk("out_phv", out_phv, h.phv);
      chk("out_port", 512'(out_egress_port), 512'(h.port));
      chk("out_mirror", 512'(out_mirror), 512'(h.mir));
      chk("drop_count", 512'(drop_count), 512'(xs(mdl_drop)));
      chk("ovf_count", 512'(overflow_count), 512'(xs(mdl_ovf)));
   endtask

   task automatic tick(input logic v, input logic [511:0] phv,
                       input logic [63:0] meta, input logic [7:0] act,
                       input logic rdy);
      ent_t e;
      logic req;
      logic pop;
      in_valid    = v;
      in_phv      = phv;
      in_metadata = meta;
      in_action   = act;
      out_ready   = rdy;
      pop = (mq.size() != 0) && rdy;
      req = 1'b0;
      if (pv_valid) begin
         if (act == 8'h00) mdl_drop++;
         else begin
            req = 1'b1;
            e = ref_exec(pv_phv, pv_meta, act);
         end
      end
      if (pop) mlast = mq.pop_front();
      if (req) begin
         if (mq.size() < 4) mq.push_back(e);
         else mdl_ovf++;
      end
      pv_valid = v;
      pv_phv   = phv;
      pv_meta  = meta;
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic beat(input logic v, input logic [511:0] phv,
                       input logic [63:0] meta, input logic [7:0] act,
                       input logic rdy);
      tick(v, phv, meta, pend_act, rdy);
      pend_act = v ? act : 8'($urandom);
   endtask

   function automatic logic [511:0] pat(input int k);
      return {16{32'hB0000000 + 32'(k)}};
   endfunction

   function automatic logic [511:0] rnd_phv();
      logic [511:0] p;
      for (int i = 0; i < 16; i++) p[32*i +: 32] = $urandom;
      return p;
   endfunction

   localparam logic [63:0] M_FWD5 = 64'h0000_0000_0000_0500;

   vec_t tbl[10];

   initial begin
      logic [31:0] m0;
      int nout;
      logic [7:0] a;

      tbl[0] = '{act:8'h01, meta:M_FWD5, phv:P0, drop:1'b0,
                 port:8'h05, mir:1'b0, exp_phv:P0};
      tbl[1] = '{act:8'h02, meta:{32'hDEADBEEF, 12'h0, 4'd3, 8'h99, 8'h00},
                 phv:P0, drop:1'b0, port:8'h3C, mir:1'b0,
                 exp_phv:{P0[511:128], 32'hDEADBEEF, P0[95:0]}};
      tbl[2] = '{act:8'h02, meta:{32'hCAFEF00D, 12'h0, 4'd15, 16'h0},
                 phv:P0, drop:1'b0, port:8'h3C, mir:1'b0,
                 exp_phv:{32'hCAFEF00D, P0[479:0]}};
      tbl[3] = '{act:8'h02, meta:{32'h12345678, 12'h0, 4'd0, 16'h0},
                 phv:P0, drop:1'b0, port:8'h3C, mir:1'b0,
                 exp_phv:{P0[511:32], 32'h12345678}};
      tbl[4] = '{act:8'h03, meta:{32'hFFFF0000, 16'h0005, 8'hA7, 8'h11},
                 phv:~P0, drop:1'b0, port:8'hA7, mir:1'b0, exp_phv:~P0};
      tbl[5] = '{act:8'h04, meta:{32'hFFFFFFFF, 16'h0002, 8'h77, 8'h00},
                 phv:P0, drop:1'b0, port:8'h3C, mir:1'b1, exp_phv:P0};
      tbl[6] = '{act:8'hFF, meta:{32'hFFFFFFFF, 16'h0002, 8'h77, 8'h00},
                 phv:P0, drop:1'b0, port:8'h3C, mir:1'b0, exp_phv:P0};
      tbl[7] = '{act:8'h42, meta:M_FWD5, phv:~P0, drop:1'b0,
                 port:8'h3C, mir:1'b0, exp_phv:~P0};
      tbl[8] = '{act:8'h00, meta:M_FWD5, phv:P0, drop:1'b1,
                 port:8'h00, mir:1'b0, exp_phv:P0};
      tbl[9] = '{act:8'h05, meta:{32'hDEADBEEF, 12'h0, 4'd1, 16'h0},
                 phv:P0, drop:1'b0, port:8'h3C, mir:1'b0, exp_phv:P0};

      rst_n = 1'b0;
      cfg_default_port = 8'h3C;
      in_valid = 1'b0;
      in_phv = '0;
      in_metadata = '0;
      in_action = '0;
      out_ready = 1'b0;
      mlast = '{phv:'0, port:'0, mir:1'b0};
      mdl_drop = '0;
      mdl_ovf = '0;
      pv_valid = 1'b0;
      pv_phv = '0;
      pv_meta = '0;
      pend_act = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_state();
      chk("rst_phv", out_phv, 512'd0);
      chk("rst_drop", 512'(drop_count), 512'd0);
      rst_n = 1'b1;
      beat(1'b0, '0, '0, 8'h00, 1'b1);

      for (int i = 0; i < 10; i++) begin
         beat(1'b1, tbl[i].phv, tbl[i].meta, tbl[i].act, 1'b1);
         chk("tbl_lat1", 512'(out_valid), 512'd0);
         beat(1'b0, '0, '0, 8'h00, 1'b1);
         chk($sformatf("tbl%0d_valid", i), 512'(out_valid),
             512'(!tbl[i].drop));
         if (!tbl[i].drop) begin
            chk($sformatf("tbl%0d_phv", i), out_phv, tbl[i].exp_phv);
            chk($sformatf("tbl%0d_port", i), 512'(out_egress_port),
                512'(tbl[i].port));
            chk($sformatf("tbl%0d_mir", i), 512'(out_mirror),
                512'(tbl[i].mir));
         end
         beat(1'b0, '0, '0, 8'h00, 1'b1);
      end

      // DROP then FORWARD back-to-back
      m0 = mdl_drop;
      nout = 0;
      beat(1'b1, pat(1), M_FWD5, 8'h00, 1'b1);
      if (out_valid) nout++;
      beat(1'b1, pat(2), M_FWD5, 8'h01, 1'b1);
      if (out_valid) nout++;
      for (int i = 0; i < 3; i++) begin
         beat(1'b0, '0, '0, 8'h00, 1'b1);
         if (out_valid) nout++;
      end
      chk("b2b_outs", 512'(nout), 512'd1);
      chk("b2b_drop", 512'(drop_count), 512'(xs(m0 + 32'd1)));

      // Six beats into a stalled FIFO
      m0 = mdl_ovf;
      for (int k = 0; k < 6; k++) beat(1'b1, pat(k), M_FWD5, 8'h01, 1'b0);
      beat(1'b0, '0, '0, 8'h00, 1'b0);
      chk("ovf_level", 512'(fifo_level), 512'd4);
      chk("ovf_count2", 512'(overflow_count), 512'(xs(m0 + 32'd2)));
      for (int k = 0; k < 4; k++) begin
         chk("drain_phv", out_phv, pat(k));
         beat(1'b0, '0, '0, 8'h00, 1'b1);
      end
      chk("drain_empty", 512'(out_valid), 512'd0);

      // Full FIFO with simultaneous pop and push
      m0 = mdl_ovf;
      for (int k = 0; k < 5; k++) beat(1'b1, pat(10 + k), M_FWD5, 8'h01, 1'b0);
      chk("full_level", 512'(fifo_level), 512'd4);
      for (int k = 5; k < 8; k++) begin
         beat(1'b1, pat(10 + k), M_FWD5, 8'h01, 1'b1);
         chk("fullpp_level", 512'(fifo_level), 512'd4);
         chk("fullpp_head", out_phv, pat(10 + k - 4));
      end
      chk("fullpp_ovf", 512'(overflow_count), 512'(xs(m0)));
      for (int k = 0; k < 6; k++) beat(1'b0, '0, '0, 8'h00, 1'b1);

      // Asynchronous reset with three entries queued
      for (int k = 0; k < 3; k++) beat(1'b1, pat(20 + k), M_FWD5, 8'h01, 1'b0);
      beat(1'b0, '0, '0, 8'h00, 1'b0);
      chk("pre_rst_level", 512'(fifo_level), 512'd3);
      #3;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_now_valid", 512'(out_valid), 512'd0);
      chk("rst_now_level", 512'(fifo_level), 512'd0);
      mq.delete();
      mlast = '{phv:'0, port:'0, mir:1'b0};
      mdl_drop = '0;
      mdl_ovf = '0;
      pv_valid = 1'b0;
      check_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pend_act = 8'($urandom);
      beat(1'b1, pat(30), {48'h0, 8'h21, 8'h00}, 8'h01, 1'b1);
      chk("post_rst_lat1", 512'(out_valid), 512'd0);
      beat(1'b0, '0, '0, 8'h00, 1'b1);
      chk("post_rst_lat2", 512'(out_valid), 512'd1);
      chk("post_rst_phv", out_phv, pat(30));
      chk("post_rst_port", 512'(out_egress_port), 512'h21);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 15) == 0) cfg_default_port = 8'($urandom);
         case ($urandom_range(0, 7))
            0: a = 8'h00;
            1: a = 8'h01;
            2: a = 8'h02;
            3: a = 8'h03;
            4: a = 8'h04;
            5: a = 8'hFF;
            6: a = 8'($urandom);
            default: a = 8'h02;
         endcase
         beat(1'($urandom_range(0, 3) != 0), rnd_phv(),
              {$urandom, $urandom}, a, 1'($urandom_range(0, 2) != 0));
      end
      for (int k = 0; k < 8; k++) beat(1'b0, '0, '0, 8'h00, 1'b1);
      chk("final_empty", 512'(out_valid), 512'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phv_action_executor.md
# phv_action_executor

Sits directly downstream of the match-action unit. Consumes each stage result beat (PHV, metadata, action opcode) and applies the decoded action: drop, forward, field modify, redirect or copy. Surviving PHVs go into a small elastic FIFO that absorbs the unstallable pipeline against a valid/ready egress interface. The block also keeps drop and overflow statistics.

## Interface

- PHV_WIDTH, 512, PHV width in bits; multiple of 32.
- METADATA_WIDTH, 64, metadata width; must be ≥ 64.
- PORT_WIDTH, 8, egress port width; must be ≤ 8.
- FIFO_DEPTH, 4, output FIFO entries; power of two.
- FIFO_ADDR_BITS, 2, log2(FIFO_DEPTH).

Ports:

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_default_port  in  PORT_WIDTH  egress port for NOP, MODIFY and COPY beats.
- in_valid  in  1  result beat valid; no backpressure.
- in_phv  in  PHV_WIDTH  PHV of the beat.
- in_metadata  in  METADATA_WIDTH  metadata of the beat.
- in_action  in  8  opcode; valid one cycle after its in_valid beat.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_phv  out  PHV_WIDTH  processed PHV.
- out_egress_port  out  PORT_WIDTH  resolved egress port.
- out_mirror  out  1  copy-to-mirror flag.
- fifo_level  out  FIFO_ADDR_BITS+1  current FIFO occupancy.
- drop_count  out  32  beats dropped by DROP action.
- overflow_count  out  32  beats lost because the FIFO was full.

## Operation

- **Stage A** (cycle N): when in_valid=1, register in_valid, in_phv and in_metadata into stage A.
- **Stage B** (cycle N+1): combine stage A with the live in_action and decode:
  - 0x00 DROP: no push; drop_count+1.
  - 0x01 FORWARD: egress = metadata[15:8]; mirror = 0.
  - 0x02 MODIFY: word index w = metadata[19:16]. If w < PHV_WIDTH/32, replace PHV bits [32w+31:32w] with metadata[63:32]; otherwise the PHV is unchanged. Egress = cfg_default_port.
  - 0x03 REDIRECT: egress = metadata[15:8]; mirror = 0. Identical datapath to FORWARD; kept as a distinct opcode.
  - 0x04 COPY: egress = cfg_default_port; mirror = 1.
  - 0xFF NOP and any other value: egress = cfg_default_port; PHV unchanged; mirror = 0.
- Egress is truncated to PORT_WIDTH LSBs.
- **Push**: every non-DROP stage-B beat is pushed into the FIFO.
  - Full and no pop in the same cycle: the beat is discarded and overflow_count+1.
  - Full with a simultaneous pop: the push is accepted and the level stays at FIFO_DEPTH.
- **Pop**: occurs when out_valid && out_ready. out_phv, out_egress_port and out_mirror always reflect the FIFO head and hold steady while out_valid=1 and out_ready=0.
- Empty FIFO: out_valid=0 and the data outputs hold their last value. out_ready is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_level equals pushes minus pops and is never above FIFO_DEPTH.
- Counters wrap from 0xFFFFFFFF to 0.

## Timing

- Reset values: out_valid=0, out_phv=0, out_egress_port=0, out_mirror=0, fifo_level=0, drop_count=0, overflow_count=0. Stage A and the FIFO pointers are also cleared.
- in_valid at cycle N with an empty FIFO gives out_valid=1 at cycle N+2. Minimum latency is 2.
- Throughput is one beat per cycle in and out when out_ready is held at 1.
- Back-to-back beats: each stage-B decode uses the in_action present in that cycle. No opcode is reused across beats.
- Reset asserted mid-operation flushes stage A and the FIFO immediately. Beats in flight are lost and not counted.

## Configuration

- ACTION_EXEC_STATS_EN defined: drop_count and overflow_count are implemented as above.
- ACTION_EXEC_STATS_EN undefined: no counter registers are built, both outputs are tied to 0, and drop/overflow behaviour is otherwise identical.

## Test plan

- FORWARD, metadata[15:8]=0x05, out_ready=1, in_valid at cycle 10 → at cycle 12, out_valid=1, out_egress_port=0x05, out_phv equal to the input, out_mirror=0.
- MODIFY, metadata[63:32]=0xDEADBEEF, metadata[19:16]=3 → out_phv[127:96]=0xDEADBEEF, all other bits unchanged, egress=cfg_default_port.
- DROP beat followed by a FORWARD beat back-to-back → exactly one output beat and drop_count=1.
- out_ready=0 while 6 FORWARD beats arrive → fifo_level=4, overflow_count=2; the first 4 PHVs then drain in order once out_ready=1.
- FIFO full with out_ready=1 and a simultaneous push → fifo_level stays 4, overflow_count unchanged, ordering preserved.
- rst_n asserted with 3 entries queued → out_valid=0 and fifo_level=0 within the same cycle; the next beat appears 2 cycles after its in_valid.
